// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and the memory controller.
// Misses issue a single word read; a flush during a miss lets the read finish but discards the response.
module inst_cache #(
  parameter int INDEX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _fetch_req,
  input  logic [31:0] _fetch_addr,
  output logic        _inst_ready_out,
  output logic [31:0] _inst_out,
  output logic        _icache_busy,
  output logic        _mc_req,
  output logic [31:0] _mc_addr,
  input  logic        _mc_ready,
  input  logic [31:0] _mc_data
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_DROP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];
  logic               r_ready_q;
  logic [31:0]        r_inst;
  logic               r_mc_req;
  logic [31:0]        r_mc_addr;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_hit;
  logic               w_hit_pulse;
  logic               w_start;
  logic               w_fill;
  logic               w_fill_pulse;
  logic               w_unused;

  assign w_idx      = _fetch_addr[INDEX_W+1:2];
  assign w_tag      = _fetch_addr[31:INDEX_W+2];
  // The outstanding miss address doubles as the fill address.
  assign w_fill_idx = r_mc_addr[INDEX_W+1:2];
  assign w_fill_tag = r_mc_addr[31:INDEX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused   = &{1'b0, _fetch_addr[1:0]};

  assign _inst_ready_out = r_ready_q & rdy_in;
  assign _inst_out       = r_inst;
  assign _icache_busy    = (r_state != S_IDLE);
  assign _mc_req         = r_mc_req;
  assign _mc_addr        = r_mc_addr;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_hit_pulse  = 1'b0;
    w_start      = 1'b0;
    w_fill       = 1'b0;
    w_fill_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (_fetch_req && !_clear) begin
          if (w_hit) begin
            w_hit_pulse = 1'b1;
          end else begin
            w_start = 1'b1;
            w_next  = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (_mc_ready) begin
          w_fill       = 1'b1;
          w_fill_pulse = !_clear;
          w_next       = S_IDLE;
        end else if (_clear) begin
          w_next = S_DROP;
        end
      end
      S_DROP: begin
        if (_mc_ready) begin
          w_fill = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid   <= '0;
      r_ready_q <= 1'b0;
      r_inst    <= '0;
      r_mc_req  <= 1'b0;
      r_mc_addr <= '0;
    end else if (rdy_in) begin
      r_ready_q <= w_hit_pulse | w_fill_pulse;
      if (w_hit_pulse) begin
        r_inst <= r_data[w_idx];
      end else if (w_fill_pulse) begin
        r_inst <= _mc_data;
      end
      if (w_start) begin
        r_mc_req  <= 1'b1;
        r_mc_addr <= {_fetch_addr[31:2], 2'b00};
      end else if (w_fill) begin
        r_mc_req <= 1'b0;
      end
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= _mc_data;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache: a line-level reference model predicts hits and misses,
// expected instructions are queued at issue time and a separate monitor checks every delivered pulse.
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        _clear;
  logic        _fetch_req;
  logic [31:0] _fetch_addr;
  logic        _inst_ready_out;
  logic [31:0] _inst_out;
  logic        _icache_busy;
  logic        _mc_req;
  logic [31:0] _mc_addr;
  logic        _mc_ready;
  logic [31:0] _mc_data;

  inst_cache #(.INDEX_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._fetch_req(_fetch_req), ._fetch_addr(_fetch_addr),
    ._inst_ready_out(_inst_ready_out), ._inst_out(_inst_out),
    ._icache_busy(_icache_busy), ._mc_req(_mc_req), ._mc_addr(_mc_addr),
    ._mc_ready(_mc_ready), ._mc_data(_mc_data)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_q[$];
  bit          m_valid [64];
  logic [23:0] m_tag   [64];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Read-only instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h10) return 32'h00A00093;
    return (w * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[7:2]] && (m_tag[a[7:2]] == a[31:8]);
  endfunction

  initial begin : monitor
    logic [31:0] exp;
    forever begin
      @(negedge clk_in);
      if (_inst_ready_out) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_pulse", _inst_out, 32'h0);
        end else begin
          exp = sb_q.pop_front();
          check(_inst_out == exp, "inst_data", _inst_out, exp);
        end
      end
    end
  end

  // mode: 0 plain, 1 clear one cycle into the miss, 2 clear with mc_ready, 3 clear together with the request
  task automatic do_fetch(input logic [31:0] a, input int mode, input int lat);
    bit          hit;
    logic [31:0] al;
    hit = model_hit(a);
    al  = {a[31:2], 2'b00};
    @(negedge clk_in);
    _fetch_req  = 1'b1;
    _fetch_addr = a;
    _clear      = (mode == 3);
    if (mode != 3 && hit) sb_q.push_back(mem_word(a));
    @(negedge clk_in);
    _fetch_req  = 1'b0;
    _clear      = 1'b0;
    _fetch_addr = $urandom;
    if (mode == 3) begin
      check(!_icache_busy && !_mc_req && !_inst_ready_out, "clear_blocks_req",
            {29'b0, _icache_busy, _mc_req, _inst_ready_out}, 32'h0);
      return;
    end
    if (hit) begin
      check(_inst_ready_out == 1'b1, "hit_latency", {31'b0, _inst_ready_out}, 32'h1);
      check(!_mc_req && !_icache_busy, "hit_no_mem", {30'b0, _mc_req, _icache_busy}, 32'h0);
      return;
    end
    check(_mc_req == 1'b1, "miss_req", {31'b0, _mc_req}, 32'h1);
    check(_mc_addr == al, "miss_addr", _mc_addr, al);
    check(_icache_busy == 1'b1, "miss_busy", {31'b0, _icache_busy}, 32'h1);
    for (int i = 1; i < lat; i++) begin
      if (mode == 1 && i == 1) _clear = 1'b1;
      @(negedge clk_in);
      _clear = 1'b0;
      check(_mc_req && _icache_busy && _mc_addr == al, "miss_hold", _mc_addr, al);
    end
    _mc_ready = 1'b1;
    _mc_data  = mem_word(a);
    _clear    = (mode == 2);
    if (mode == 0) sb_q.push_back(mem_word(a));
    m_valid[a[7:2]] = 1'b1;
    m_tag[a[7:2]]   = a[31:8];
    @(negedge clk_in);
    _mc_ready = 1'b0;
    _clear    = 1'b0;
    _mc_data  = $urandom;
    check(!_mc_req && !_icache_busy, "fill_done", {30'b0, _mc_req, _icache_busy}, 32'h0);
    check(_inst_ready_out == (mode == 0), "fill_pulse", {31'b0, _inst_ready_out}, {31'b0, mode == 0});
  endtask

  task automatic back_to_back(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_in);
    _fetch_req  = 1'b1;
    _fetch_addr = a;
    sb_q.push_back(mem_word(a));
    @(negedge clk_in);
    check(_inst_ready_out == 1'b1, "b2b_first", {31'b0, _inst_ready_out}, 32'h1);
    _fetch_addr = b;
    sb_q.push_back(mem_word(b));
    @(negedge clk_in);
    _fetch_req = 1'b0;
    check(_inst_ready_out == 1'b1, "b2b_second", {31'b0, _inst_ready_out}, 32'h1);
  endtask

  task automatic pause_hit(input logic [31:0] a);
    @(negedge clk_in);
    _fetch_req  = 1'b1;
    _fetch_addr = a;
    sb_q.push_back(mem_word(a));
    @(posedge clk_in);
    #1;
    _fetch_req = 1'b0;
    rdy_in     = 1'b0;
    repeat (4) begin
      @(negedge clk_in);
      check(_inst_ready_out == 1'b0, "pause_quiet", {31'b0, _inst_ready_out}, 32'h0);
    end
    @(posedge clk_in);
    #1;
    rdy_in = 1'b1;
    @(negedge clk_in);
    check(_inst_ready_out == 1'b1, "pause_release", {31'b0, _inst_ready_out}, 32'h1);
    @(negedge clk_in);
    check(_inst_ready_out == 1'b0, "pause_once", {31'b0, _inst_ready_out}, 32'h0);
  endtask

  task automatic reset_mid_miss(input logic [31:0] a);
    @(negedge clk_in);
    _fetch_req  = 1'b1;
    _fetch_addr = a;
    @(negedge clk_in);
    _fetch_req = 1'b0;
    check(_mc_req == 1'b1, "rst_pre_req", {31'b0, _mc_req}, 32'h1);
    #3;
    rst_in = 1'b1;
    #1;
    check(!_mc_req && !_icache_busy && !_inst_ready_out, "rst_async_drop",
          {29'b0, _mc_req, _icache_busy, _inst_ready_out}, 32'h0);
    check(_mc_addr == 32'h0, "rst_async_addr", _mc_addr, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] a;
    int          r;
    int          mode;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _fetch_req = 1'b0;
    _fetch_addr = '0; _mc_ready = 1'b0; _mc_data = '0;
    #2;
    check(!_inst_ready_out && !_icache_busy && !_mc_req, "reset_flags",
          {29'b0, _inst_ready_out, _icache_busy, _mc_req}, 32'h0);
    check(_inst_out == 32'h0, "reset_inst", _inst_out, 32'h0);
    check(_mc_addr == 32'h0, "reset_mc_addr", _mc_addr, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;

    do_fetch(32'h10, 0, 3);
    do_fetch(32'h10, 0, 3);
    do_fetch(32'h14, 0, 2);
    back_to_back(32'h10, 32'h14);
    do_fetch(32'h110, 0, 2);
    do_fetch(32'h10, 0, 4);
    do_fetch(32'h20, 1, 3);
    do_fetch(32'h20, 0, 3);
    do_fetch(32'h24, 2, 3);
    do_fetch(32'h24, 0, 3);
    pause_hit(32'h24);
    do_fetch(32'h10, 3, 2);
    reset_mid_miss(32'h30);
    do_fetch(32'h10, 0, 2);

    for (int n = 0; n < 200; n++) begin
      a = {22'h0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 9);
      mode = (r <= 6) ? 0 : r - 6;
      do_fetch(a, mode, $urandom_range(2, 5));
    end

    repeat (2) @(negedge clk_in);
    check(sb_q.size() == 0, "sb_drain", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
Direct-mapped, one-word-per-line instruction cache between the memory controller and the instruction fetcher.
- Accepts the fetcher's word request (_fetch_req/_fetch_addr, driven from the fetcher's _InstFetcher_need_inst/_next_pc).
- Returns the 32-bit instruction on _inst_out with the _inst_ready_out pulse that feeds the fetcher's _inst_in/_inst_ready_in.
- On a miss, issues a single word read to the memory controller and fills the line.
- _icache_busy feeds the fetcher's _mem_busy.

Parameters:
INDEX_W, 6, index bits; line count = 2^INDEX_W (64 lines); index = addr[INDEX_W+1:2], tag = addr[31:INDEX_W+2].

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  pause when low: all registers hold
_clear  input  1  pipeline flush from ROB misprediction
_fetch_req  input  1  fetcher requests word at _fetch_addr
_fetch_addr  input  32  byte address of instruction; bits [1:0] ignored
_inst_ready_out  output  1  one-cycle pulse: _inst_out valid
_inst_out  output  32  instruction word
_icache_busy  output  1  high when state != IDLE; requests are ignored while high
_mc_req  output  1  word read request to memory controller, level, held until _mc_ready
_mc_addr  output  32  {miss_addr[31:2],2'b00}, stable while _mc_req high
_mc_ready  input  1  one-cycle pulse: _mc_data valid for the current _mc_req
_mc_data  input  32  returned word

Behaviour:
- Reset (async, rst_in=1):
  - Registers: state=IDLE, all valid bits=0, ready_q=0, _inst_out=0, _mc_req=0, _mc_addr=0.
  - Tag/data arrays need no reset.
- Pause: while rdy_in=0, no register or array changes.
  - _inst_ready_out = ready_q & rdy_in, so a pending pulse is delivered on the first cycle rdy_in is high again.
- ready_q defaults to 0 each active cycle unless set below. A pulse lasts exactly one active cycle.
- States:
  - IDLE: no outstanding memory read.
  - MISS: read outstanding; the response will be delivered.
  - DROP: read outstanding; the response will be discarded.
- IDLE with _clear=1:
  - No lookup; ready_q<=0. Any pulse scheduled for this edge is suppressed.
- IDLE with _fetch_req=1 and _clear=0: lookup uses the combinational array read.
  - Hit (valid[idx] & tag match): next cycle ready_q=1, _inst_out=data[idx]. State stays IDLE.
  - Back-to-back hits give one instruction per cycle.
  - Miss: latch miss_addr; _mc_req<=1, _mc_addr<=aligned address; go to MISS.
- MISS, _mc_ready=1, _clear=0:
  - Write data/tag/valid at miss index (evicts any prior line).
  - Next cycle ready_q=1, _inst_out=_mc_data.
  - _mc_req<=0; go to IDLE. Miss latency = memory latency + 1 cycle.
- MISS, _clear=1, _mc_ready=0:
  - Go to DROP. _mc_req stays high; the memory transaction must complete.
- MISS, _clear=1 and _mc_ready=1 in the same cycle:
  - Fill the line, no pulse, _mc_req<=0, go to IDLE.
- DROP, _mc_ready=1:
  - Fill the line (instruction memory is read-only, so the data is valid), no pulse.
  - _mc_req<=0; go to IDLE. Further _clear in DROP has no effect.
- A new fetch is accepted only in IDLE. The fetcher must re-assert _fetch_req after _icache_busy falls; requests seen while busy are ignored, not queued.
- Valid bits are cleared only by reset, never by _clear.
- _mc_ready while in IDLE (protocol violation) is ignored.

Test Plan:
- Cold miss: reset, _fetch_req with addr 0x0000_0010; MC returns 0x00A00093 three cycles later → _mc_req=1, _mc_addr=0x10, _icache_busy=1 until _mc_ready; _inst_ready_out pulses one cycle after _mc_ready with _inst_out=0x00A00093.
- Hit: same addr again → _inst_ready_out=1 next cycle, _inst_out=0x00A00093, _mc_req stays 0. Consecutive hits on 0x10 and 0x14 (both filled) → pulses on two consecutive cycles.
- Conflict eviction: fill 0x0000_0010, then fetch 0x0000_0110 (same index, different tag) → miss, _mc_addr=0x110. A refetch of 0x10 then misses again.
- Clear mid-miss: miss on 0x20, _clear at cycle 1, _mc_ready at cycle 3 → no _inst_ready_out. State returns to IDLE after _mc_ready; refetch of 0x20 hits. Repeat with _clear coincident with _mc_ready → same result.
- Pause: a hit is scheduled, rdy_in=0 for 4 cycles → _inst_ready_out=0 during the pause, then pulses exactly once on the first cycle rdy_in=1, data intact.
- Reset mid-miss: assert rst_in asynchronously while in MISS → _mc_req, _icache_busy and _inst_ready_out drop immediately. A previously cached address misses after reset.
